// File: rtl/acc_drain.sv
// Snapshots NUM_ACC packed 32-bit accumulators on capture and drains them one word per
// valid/ready transfer. Optional 16-bit unsigned saturation of out_data under ACC_DRAIN_SAT16_EN.
module acc_drain #(
    parameter int unsigned NUM_ACC = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [32*NUM_ACC-1:0]  acc_in,
    input  logic                   capture,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [31:0]            out_data,
    output logic [3:0]             out_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun,
    output logic                   sat
);

    localparam int unsigned IdxW    = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam logic [3:0]  LastIdx = 4'(NUM_ACC - 1);

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        overrun_q, overrun_d;
    logic        load;
    logic [31:0] snap_q [NUM_ACC];
    logic [31:0] word;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        load      = 1'b0;
        // Any capture outside IDLE is dropped and remembered, including the DONE cycle.
        overrun_d = overrun_q | (capture && (state_q != StIdle));
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    load    = 1'b1;
                    idx_d   = 4'd0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (out_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= 4'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_ACC; k++) begin
                snap_q[k] <= 32'd0;
            end
        end else if (load) begin
            for (int unsigned k = 0; k < NUM_ACC; k++) begin
                snap_q[k] <= acc_in[32*k +: 32];
            end
        end
    end

    assign word = snap_q[idx_q[IdxW-1:0]];

    // Outputs decode straight from state so an asynchronous reset silences them at once.
    always_comb begin
        out_valid = (state_q == StSend);
        out_idx   = idx_q;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        overrun   = overrun_q;
`ifdef ACC_DRAIN_SAT16_EN
        sat       = out_valid && (word > 32'h0000FFFF);
        out_data  = !out_valid ? 32'd0 : (sat ? 32'h0000FFFF : word);
`else
        sat       = 1'b0;
        out_data  = out_valid ? word : 32'd0;
`endif
    end

endmodule

// File: tb/tb_acc_drain.sv
// Scoreboard bench for acc_drain: stimulus pushes expected words, a negedge monitor pops on
// every transfer and checks held words while stalled.
module tb_acc_drain;

    localparam int unsigned NUM_ACC = 4;

    logic                  clk;
    logic                  reset;
    logic [32*NUM_ACC-1:0] acc_in;
    logic                  capture;
    logic                  out_ready;
    logic                  out_valid;
    logic [31:0]           out_data;
    logic [3:0]            out_idx;
    logic                  busy;
    logic                  done;
    logic                  overrun;
    logic                  sat;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        sat;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    logic done_next;

    acc_drain #(.NUM_ACC(NUM_ACC)) dut (
        .clk       (clk),
        .reset     (reset),
        .acc_in    (acc_in),
        .capture   (capture),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_data(input logic [31:0] w);
`ifdef ACC_DRAIN_SAT16_EN
        return (w > 32'h0000FFFF) ? 32'h0000FFFF : w;
`else
        return w;
`endif
    endfunction

    function automatic logic model_sat(input logic [31:0] w);
`ifdef ACC_DRAIN_SAT16_EN
        return w > 32'h0000FFFF;
`else
        return (w != w);
`endif
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle showing word 0.
    task automatic do_capture(input logic [32*NUM_ACC-1:0] vals);
        exp_t e;
        acc_in  = vals;
        capture = 1'b1;
        for (int k = 0; k < NUM_ACC; k++) begin
            e.data = model_data(vals[32*k +: 32]);
            e.idx  = 4'(k);
            e.sat  = model_sat(vals[32*k +: 32]);
            e.last = (k == NUM_ACC - 1);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        capture = 1'b0;
        acc_in  = ~vals;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 60 && busy; n++) begin
            @(posedge clk);
            #1;
        end
        check(name, busy, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h idx %0d expected none", out_data,
                             out_idx);
                end else begin
                    e = sb[0];
                    check("word_data", out_data, e.data);
                    check("word_idx", out_idx, e.idx);
                    check("word_sat", sat, e.sat);
                    if (out_ready) begin
                        void'(sb.pop_front());
                    end
                end
            end else begin
                check("idle_data_zero", out_data, 32'd0);
            end
            check("done_pulse", done, done_next);
            done_next = out_valid && out_ready && (sb.size() >= 0) && (out_idx == 4'(NUM_ACC - 1));
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        done_next = 1'b0;
        reset     = 1'b1;
        capture   = 1'b0;
        out_ready = 1'b0;
        acc_in    = '0;
        #2;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 32'd0);
        check("rst_idx", out_idx, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_sat", sat, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Straight drain at full rate; capture on the first edge after reset.
        out_ready = 1'b1;
        do_capture({32'd40, 32'd30, 32'd20, 32'd10});
        for (int i = 0; i < NUM_ACC; i++) begin
            check("t1_valid_run", out_valid, 1'b1);
            @(posedge clk);
            #1;
        end
        check("t1_done", done, 1'b1);
        check("t1_busy_in_done", busy, 1'b1);
        @(posedge clk);
        #1;
        check("t1_busy_low", busy, 1'b0);
        check("t1_done_low", done, 1'b0);

        // Stalled drain with ready pattern 1,0,0 repeating.
        do_capture({32'h0000_0444, 32'h0000_0333, 32'h0000_0222, 32'h0000_0111});
        for (int c = 0; c < 40 && busy; c++) begin
            out_ready = (c % 3 == 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_idle("t2_idle");
        check("t2_sb_empty", sb.size(), 0);

        // Capture during SEND and during DONE: ignored, overrun sticks.
        do_capture({32'd8, 32'd7, 32'd6, 32'd5});
        acc_in  = {NUM_ACC{32'd99}};
        capture = 1'b1;
        @(posedge clk);
        #1;
        capture = 1'b0;
        check("t3_overrun_set", overrun, 1'b1);
        for (int n = 0; n < 20 && !done; n++) begin
            @(posedge clk);
            #1;
        end
        check("t3_reached_done", done, 1'b1);
        capture = 1'b1;
        @(posedge clk);
        #1;
        capture = 1'b0;
        check("t3_done_capture_ignored", busy, 1'b0);
        @(posedge clk);
        #1;
        check("t3_still_idle", out_valid, 1'b0);
        check("t3_overrun_sticky", overrun, 1'b1);
        check("t3_sb_empty", sb.size(), 0);

        // Reset after the second word transfers.
        do_capture({32'd4, 32'd3, 32'd2, 32'd1});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        done_next = 1'b0;
        #1;
        check("t4_valid_low", out_valid, 1'b0);
        check("t4_busy_low", busy, 1'b0);
        check("t4_overrun_clr", overrun, 1'b0);
        check("t4_idx_zero", out_idx, 4'd0);
        @(posedge clk);
        #1;
        check("t4_no_done", done, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("t4_no_done_after", done, 1'b0);
        do_capture({32'd14, 32'd13, 32'd12, 32'd11});
        check("t4_fresh_idx0", out_idx, 4'd0);
        wait_idle("t4_idle");
        check("t4_sb_empty", sb.size(), 0);

        // Saturation boundary values.
        do_capture({32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0001_2345});
`ifdef ACC_DRAIN_SAT16_EN
        check("t5_word0_hand", out_data, 32'h0000_FFFF);
        check("t5_sat0_hand", sat, 1'b1);
`else
        check("t5_word0_hand", out_data, 32'h0001_2345);
        check("t5_sat0_hand", sat, 1'b0);
`endif
        wait_idle("t5_idle");
        check("t5_sb_empty", sb.size(), 0);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no end expected end before 20000");
        $fatal(1, "timeout");
    end

endmodule
